// File: rtl/cache_assoc_datapath.sv
// N-way set-associative cache datapath: data/tag/valid/dirty arrays, tree-PLRU victim selection.
// Optional flush walker (write back dirty lines, then invalidate) is built when CACHE_FLUSH_EN is defined.
module cache_assoc_datapath #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX,
    localparam int S_LINE  = 8 * (2 ** S_OFFSET),
    localparam int S_WAY   = $clog2(NUM_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_address,
    input  logic [S_LINE-1:0]     mem_wdata256,
    input  logic [S_LINE/8-1:0]   mem_byte_enable256,
    input  logic [S_LINE-1:0]     pmem_rdata,
    input  logic                  fill,
    input  logic                  write_hit,
    input  logic                  lru_update,
    input  logic                  pmem_address_sel,
    input  logic                  flush_req,
    input  logic                  wb_ready,
    output logic                  hit,
    output logic [S_WAY-1:0]      hit_way,
    output logic [S_WAY-1:0]      victim_way,
    output logic                  victim_valid,
    output logic                  victim_dirty,
    output logic [S_LINE-1:0]     data_way_out,
    output logic [31:0]           pmem_address,
    output logic [S_LINE-1:0]     pmem_wdata,
    output logic                  wb_valid,
    output logic                  flush_busy,
    output logic                  flush_done
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int CW       = S_INDEX + S_WAY;

    logic [S_LINE-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    logic [S_TAG-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

    logic [S_INDEX-1:0]  idx;
    logic [S_TAG-1:0]    req_tag;
    logic                unused_offset;

    assign idx           = mem_address[S_OFFSET +: S_INDEX];
    assign req_tag       = mem_address[31 -: S_TAG];
    assign unused_offset = ^mem_address[S_OFFSET-1:0];

    logic [CW-1:0]       fcnt;
    logic [S_INDEX-1:0]  fset;
    logic [S_WAY-1:0]    fway;
    logic                clr_entry;
    logic                clr_plru;

    assign fset = fcnt[CW-1 -: S_INDEX];
    assign fway = fcnt[S_WAY-1:0];

    logic                hit_raw;
    logic                inv_found;
    logic [S_WAY-1:0]    hit_raw_way;
    logic [S_WAY-1:0]    inv_way;
    logic [S_WAY-1:0]    plru_way;
    logic [S_WAY-1:0]    access_way;
    logic [NUM_WAYS-2:0] plru_upd;
    logic [S_LINE-1:0]   merged;

    // PLRU nodes use heap order (children of n are 2n+1, 2n+2), so one ascending pass walks the tree.
    always_comb begin
        int unsigned node;
        int unsigned cur;
        int unsigned parent;
        hit_raw     = 1'b0;
        hit_raw_way = '0;
        inv_found   = 1'b0;
        inv_way     = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag && !hit_raw) begin
                hit_raw     = 1'b1;
                hit_raw_way = S_WAY'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = S_WAY'(w);
            end
        end

        node = 0;
        for (int unsigned n = 0; n < NUM_WAYS - 1; n++) begin
            if (n == node) node = 2 * node + (plru_q[idx][n] ? 32'd2 : 32'd1);
        end
        plru_way = S_WAY'(node - 32'(NUM_WAYS - 1));

        plru_upd = plru_q[idx];
        cur      = 32'(NUM_WAYS - 1) + 32'(access_way);
        for (int unsigned k = 0; k < S_WAY; k++) begin
            parent           = (cur - 1) >> 1;
            plru_upd[parent] = cur[0];
            cur              = parent;
        end

        merged = data_q[idx][hit_raw_way];
        for (int unsigned b = 0; b < S_LINE / 8; b++) begin
            if (mem_byte_enable256[b]) merged[8*b +: 8] = mem_wdata256[8*b +: 8];
        end
    end

    assign hit          = hit_raw & ~flush_busy;
    assign hit_way      = hit ? hit_raw_way : '0;
    assign victim_way   = inv_found ? inv_way : plru_way;
    assign access_way   = hit ? hit_raw_way : victim_way;
    assign victim_valid = valid_q[idx][victim_way];
    assign victim_dirty = dirty_q[idx][victim_way];
    assign data_way_out = data_q[idx][hit ? hit_raw_way : victim_way];
    assign pmem_wdata   = flush_busy ? data_q[fset][fway] : data_q[idx][victim_way];

    always_comb begin
        if (flush_busy)
            pmem_address = {tag_q[fset][fway], fset, {S_OFFSET{1'b0}}};
        else if (pmem_address_sel)
            pmem_address = {tag_q[idx][victim_way], idx, {S_OFFSET{1'b0}}};
        else
            pmem_address = {req_tag, idx, {S_OFFSET{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '{default: '0};
            tag_q   <= '{default: '0};
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            plru_q  <= '{default: '0};
        end else if (flush_busy) begin
            if (clr_entry) begin
                valid_q[fset][fway] <= 1'b0;
                dirty_q[fset][fway] <= 1'b0;
            end
            if (clr_plru) plru_q[fset] <= '0;
        end else begin
            if (fill) begin
                data_q[idx][victim_way]  <= pmem_rdata;
                tag_q[idx][victim_way]   <= req_tag;
                valid_q[idx][victim_way] <= 1'b1;
                dirty_q[idx][victim_way] <= 1'b0;
            end else if (write_hit && hit) begin
                data_q[idx][hit_raw_way]  <= merged;
                dirty_q[idx][hit_raw_way] <= 1'b1;
            end
            if (lru_update) plru_q[idx] <= plru_upd;
        end
    end

`ifdef CACHE_FLUSH_EN
    typedef enum logic [1:0] {F_IDLE, F_SCAN, F_WB} fstate_t;

    fstate_t       state, state_next;
    logic [CW-1:0] fcnt_next;
    logic          done_q, done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= F_IDLE;
            fcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            fcnt   <= fcnt_next;
            done_q <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        done_next  = 1'b0;
        clr_entry  = 1'b0;
        clr_plru   = 1'b0;
        unique case (state)
            F_IDLE: begin
                if (flush_req) begin
                    state_next = F_SCAN;
                    fcnt_next  = '0;
                end
            end
            F_SCAN: begin
                clr_plru = (fway == '0);
                if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
                    state_next = F_WB;
                end else begin
                    clr_entry = 1'b1;
                    fcnt_next = fcnt + CW'(1);
                    if (fcnt == '1) begin
                        state_next = F_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            F_WB: begin
                if (wb_ready) begin
                    clr_entry  = 1'b1;
                    fcnt_next  = fcnt + CW'(1);
                    state_next = (fcnt == '1) ? F_IDLE : F_SCAN;
                    done_next  = (fcnt == '1);
                end
            end
            default: state_next = F_IDLE;
        endcase
    end

    assign flush_busy = (state != F_IDLE);
    assign wb_valid   = (state == F_WB);
    assign flush_done = done_q;
`else
    logic unused_flush;

    assign unused_flush = flush_req ^ wb_ready;
    assign fcnt         = '0;
    assign clr_entry    = 1'b0;
    assign clr_plru     = 1'b0;
    assign flush_busy   = 1'b0;
    assign wb_valid     = 1'b0;
    assign flush_done   = 1'b0;
`endif

endmodule

// File: tb/tb_cache_assoc_datapath.sv
// Directed self-checking bench for cache_assoc_datapath (default 4-way, 8 sets, 256-bit lines).
// Flush scenarios are exercised when CACHE_FLUSH_EN is defined; otherwise the walker is checked to be inert.
`timescale 1ns/1ps
module tb_cache_assoc_datapath;
    localparam int LW = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     mem_address;
    logic [LW-1:0]   mem_wdata256;
    logic [LW/8-1:0] mem_byte_enable256;
    logic [LW-1:0]   pmem_rdata;
    logic            fill, write_hit, lru_update, pmem_address_sel, flush_req, wb_ready;
    logic            hit;
    logic [1:0]      hit_way, victim_way;
    logic            victim_valid, victim_dirty;
    logic [LW-1:0]   data_way_out;
    logic [31:0]     pmem_address;
    logic [LW-1:0]   pmem_wdata;
    logic            wb_valid, flush_busy, flush_done;

    int tests = 0;
    int fails = 0;

    logic [LW-1:0] line_x;
    logic [LW-1:0] line_y;

    always #5 clk = ~clk;

    cache_assoc_datapath #(.S_OFFSET(5), .S_INDEX(3), .NUM_WAYS(4)) dut (
        .clk(clk), .rst(rst), .mem_address(mem_address), .mem_wdata256(mem_wdata256),
        .mem_byte_enable256(mem_byte_enable256), .pmem_rdata(pmem_rdata), .fill(fill),
        .write_hit(write_hit), .lru_update(lru_update), .pmem_address_sel(pmem_address_sel),
        .flush_req(flush_req), .wb_ready(wb_ready), .hit(hit), .hit_way(hit_way),
        .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .data_way_out(data_way_out), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .wb_valid(wb_valid), .flush_busy(flush_busy), .flush_done(flush_done)
    );

    function automatic logic [LW-1:0] pat(input int t);
        logic [31:0] w;
        w = 32'h0101_0101 * t;
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; fill = 0; write_hit = 0; lru_update = 0; pmem_address_sel = 0;
        flush_req = 0; wb_ready = 0; mem_wdata256 = '0; mem_byte_enable256 = '0; pmem_rdata = '0;
        mem_address = 32'h0000_1240;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL reset_hit got %0b want 0", hit); end
        tests++; if (hit_way !== 2'd0) begin fails++; $display("FAIL reset_hit_way got %0d want 0", hit_way); end
        tests++; if (victim_way !== 2'd0) begin fails++; $display("FAIL reset_victim_way got %0d want 0", victim_way); end
        tests++; if (victim_valid !== 1'b0) begin fails++; $display("FAIL reset_victim_valid got %0b want 0", victim_valid); end
        tests++; if (victim_dirty !== 1'b0) begin fails++; $display("FAIL reset_victim_dirty got %0b want 0", victim_dirty); end
        tests++; if ({wb_valid, flush_busy, flush_done} !== 3'b000) begin fails++;
            $display("FAIL reset_flush_outs got %b want 000", {wb_valid, flush_busy, flush_done}); end
        tests++; if (data_way_out !== '0) begin fails++; $display("FAIL reset_data got %h want 0", data_way_out); end
        mem_address = 32'h0000_125F;
        #1;
        tests++; if (pmem_address !== 32'h0000_1240) begin fails++;
            $display("FAIL addr_align got %h want 00001240", pmem_address); end
    endtask

    task automatic test_fill_plru();
        for (int t = 1; t <= 4; t++) begin
            mem_address = (t << 8) | 32'h40;
            pmem_rdata = pat(t);
            fill = 1; lru_update = 1;
            #1;
            tests++; if (victim_way !== 2'(t - 1) || victim_valid !== 1'b0) begin fails++;
                $display("FAIL fill_victim_%0d got way %0d valid %0b want way %0d valid 0", t, victim_way, victim_valid, t - 1); end
            tick();
            fill = 0; lru_update = 0;
        end
        mem_address = 32'h0000_0540;
        #1;
        tests++; if (hit !== 1'b0 || victim_way !== 2'd0 || victim_valid !== 1'b1 || victim_dirty !== 1'b0) begin fails++;
            $display("FAIL full_set_victim got hit %0b way %0d v %0b d %0b want 0 0 1 0", hit, victim_way, victim_valid, victim_dirty); end
        mem_address = 32'h0000_0340;
        #1;
        tests++; if (hit !== 1'b1 || hit_way !== 2'd2) begin fails++;
            $display("FAIL hit_tag3 got hit %0b way %0d want 1 2", hit, hit_way); end
        tests++; if (data_way_out !== pat(3)) begin fails++; $display("FAIL hit_tag3_data got %h want %h", data_way_out, pat(3)); end
        mem_address = 32'h0000_0140; lru_update = 1;
        #1;
        tests++; if (hit_way !== 2'd0) begin fails++; $display("FAIL hit_tag1 got way %0d want 0", hit_way); end
        tick();
        lru_update = 0; mem_address = 32'h0000_0540;
        #1;
        tests++; if (victim_way !== 2'd2) begin fails++; $display("FAIL plru_after_tag1 got %0d want 2", victim_way); end
    endtask

    task automatic test_write_hit();
        logic [LW-1:0] expl;
        expl = pat(2);
        expl[31:0] = 32'hDEAD_BEEF;
        mem_address = 32'h0000_0240;
        mem_wdata256 = {{7{32'hFFFF_FFFF}}, 32'hDEAD_BEEF};
        mem_byte_enable256 = 32'h0000_000F;
        write_hit = 1;
        tick();
        write_hit = 0; mem_byte_enable256 = '0;
        #1;
        tests++; if (data_way_out[31:0] !== 32'hDEAD_BEEF) begin fails++;
            $display("FAIL wh_low got %h want deadbeef", data_way_out[31:0]); end
        tests++; if (data_way_out !== expl) begin fails++; $display("FAIL wh_line got %h want %h", data_way_out, expl); end
        mem_address = 32'h0000_0340; lru_update = 1;
        tick();
        lru_update = 0; mem_address = 32'h0000_0540; pmem_address_sel = 1;
        #1;
        tests++; if (victim_way !== 2'd1 || victim_dirty !== 1'b1) begin fails++;
            $display("FAIL wh_dirty got way %0d dirty %0b want 1 1", victim_way, victim_dirty); end
        tests++; if (pmem_address !== 32'h0000_0240) begin fails++; $display("FAIL wh_victim_addr got %h want 00000240", pmem_address); end
        tests++; if (data_way_out !== expl) begin fails++; $display("FAIL miss_victim_line got %h want %h", data_way_out, expl); end
        pmem_address_sel = 0;
    endtask

    task automatic test_dirty_victim();
        mem_address = 32'h000A_BC40; pmem_rdata = pat(10); fill = 1;
        #1;
        tests++; if (hit !== 1'b0 || victim_way !== 2'd1) begin fails++;
            $display("FAIL dv_pre got hit %0b way %0d want 0 1", hit, victim_way); end
        tick();
        fill = 0;
        #1;
        tests++; if (hit !== 1'b1 || hit_way !== 2'd1 || victim_dirty !== 1'b0) begin fails++;
            $display("FAIL dv_fill got hit %0b way %0d dirty %0b want 1 1 0", hit, hit_way, victim_dirty); end
        mem_wdata256 = line_x; mem_byte_enable256 = '1; write_hit = 1;
        tick();
        write_hit = 0; mem_byte_enable256 = '0;
        mem_address = 32'h0000_5540; pmem_address_sel = 1;
        #1;
        tests++; if (victim_way !== 2'd1 || victim_dirty !== 1'b1) begin fails++;
            $display("FAIL dv_victim got way %0d dirty %0b want 1 1", victim_way, victim_dirty); end
        tests++; if (pmem_address !== 32'h000A_BC40) begin fails++; $display("FAIL dv_addr got %h want 000abc40", pmem_address); end
        tests++; if (pmem_wdata !== line_x) begin fails++; $display("FAIL dv_wdata got %h want %h", pmem_wdata, line_x); end
        pmem_address_sel = 0;
        #1;
        tests++; if (pmem_address !== 32'h0000_5540) begin fails++; $display("FAIL req_addr got %h want 00005540", pmem_address); end
        mem_address = 32'h0000_7740; mem_wdata256 = '0; mem_byte_enable256 = '1; write_hit = 1;
        tick();
        write_hit = 0; mem_byte_enable256 = '0; mem_address = 32'h0000_5540;
        #1;
        tests++; if (pmem_wdata !== line_x) begin fails++; $display("FAIL wh_miss_noeffect got %h want %h", pmem_wdata, line_x); end
        // fill and write_hit together in set 5: fill data must win
        mem_address = 32'h0000_09A0; pmem_rdata = pat(9); mem_wdata256 = '1; mem_byte_enable256 = '1;
        fill = 1; write_hit = 1;
        tick();
        fill = 0; write_hit = 0; mem_byte_enable256 = '0;
        #1;
        tests++; if (hit !== 1'b1 || data_way_out !== pat(9)) begin fails++;
            $display("FAIL fill_wins got hit %0b data %h want 1 %h", hit, data_way_out, pat(9)); end
        mem_wdata256 = line_y; mem_byte_enable256 = '1; write_hit = 1;
        tick();
        write_hit = 0; mem_byte_enable256 = '0;
        #1;
        tests++; if (data_way_out !== line_y) begin fails++; $display("FAIL set5_write got %h want %h", data_way_out, line_y); end
    endtask

`ifdef CACHE_FLUSH_EN
    task automatic test_flush();
        logic [31:0]   exp_addr [2];
        logic [LW-1:0] exp_data [2];
        logic [31:0]   held_addr;
        logic [LW-1:0] held_data;
        logic [31:0]   probe [5];
        int busy_cycles = 0, done_pulses = 0, wcnt = 0, wb_seen = 0, unstable = 0;
        bit finished = 0;
        exp_addr[0] = 32'h000A_BC40; exp_data[0] = line_x;
        exp_addr[1] = 32'h0000_09A0; exp_data[1] = line_y;
        held_addr = '0; held_data = '0;
        mem_address = 32'h0000_0340; flush_req = 1; wb_ready = 0;
        #1;
        tests++; if (flush_busy !== 1'b0 || hit !== 1'b1) begin fails++;
            $display("FAIL flush_pre got busy %0b hit %0b want 0 1", flush_busy, hit); end
        tick();
        flush_req = 0;
        #1;
        tests++; if (flush_busy !== 1'b1 || hit !== 1'b0) begin fails++;
            $display("FAIL flush_start got busy %0b hit %0b want 1 0", flush_busy, hit); end
        for (int c = 0; c < 200 && !finished; c++) begin
            if (flush_done) done_pulses++;
            if (flush_busy) busy_cycles++; else finished = 1;
            if (wb_valid) begin
                wcnt++;
                if (wcnt == 1) begin
                    held_addr = pmem_address; held_data = pmem_wdata;
                    tests++;
                    if (wb_seen < 2) begin
                        if (held_addr !== exp_addr[wb_seen] || held_data !== exp_data[wb_seen]) begin fails++;
                            $display("FAIL wb%0d got addr %h want %h (data match %0b)", wb_seen, held_addr, exp_addr[wb_seen], held_data === exp_data[wb_seen]); end
                    end else begin
                        fails++; $display("FAIL wb_extra got writeback %0d at %h want none", wb_seen, held_addr);
                    end
                end else if (pmem_address !== held_addr || pmem_wdata !== held_data) begin
                    unstable++;
                end
                wb_ready = (wcnt == 4);
                if (wcnt == 4) wb_seen++;
            end else begin
                wcnt = 0; wb_ready = 0;
            end
            if (!finished) tick();
        end
        wb_ready = 0;
        tests++; if (finished !== 1'b1) begin fails++; $display("FAIL flush_timeout got busy after 200 cycles want idle"); end
        tests++; if (busy_cycles !== 40) begin fails++; $display("FAIL flush_cycles got %0d want 40", busy_cycles); end
        tests++; if (wb_seen !== 2) begin fails++; $display("FAIL flush_wb_count got %0d want 2", wb_seen); end
        tests++; if (unstable !== 0) begin fails++; $display("FAIL wb_stable got %0d changes want 0", unstable); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (flush_done) done_pulses++;
        end
        tests++; if (done_pulses !== 1) begin fails++; $display("FAIL flush_done_pulses got %0d want 1", done_pulses); end
        probe = '{32'h0000_0140, 32'h000A_BC40, 32'h0000_0340, 32'h0000_0440, 32'h0000_09A0};
        for (int i = 0; i < 5; i++) begin
            mem_address = probe[i];
            #1;
            tests++; if (hit !== 1'b0 || victim_valid !== 1'b0) begin fails++;
                $display("FAIL post_flush_%h got hit %0b vvalid %0b want 0 0", probe[i], hit, victim_valid); end
        end
    endtask

    task automatic test_reset_mid_flush();
        bit seen = 0;
        mem_address = 32'h0000_0140; pmem_rdata = pat(1); fill = 1;
        tick();
        fill = 0; mem_wdata256 = pat(7); mem_byte_enable256 = '1; write_hit = 1;
        tick();
        write_hit = 0; mem_byte_enable256 = '0;
        #1;
        tests++; if (hit !== 1'b1 || data_way_out !== pat(7)) begin fails++;
            $display("FAIL rmf_setup got hit %0b data %h want 1 %h", hit, data_way_out, pat(7)); end
        flush_req = 1; wb_ready = 0;
        tick();
        flush_req = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (wb_valid) seen = 1; else tick();
        end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rmf_wb_timeout got no wb_valid want wb_valid"); end
        rst = 1;
        tick();
        #1;
        tests++; if ({flush_busy, wb_valid, flush_done} !== 3'b000) begin fails++;
            $display("FAIL rmf_outs got %b want 000", {flush_busy, wb_valid, flush_done}); end
        tests++; if (hit !== 1'b0 || victim_valid !== 1'b0) begin fails++;
            $display("FAIL rmf_invalid got hit %0b vvalid %0b want 0 0", hit, victim_valid); end
        rst = 0;
        tick();
        tests++; if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin fails++;
            $display("FAIL rmf_after got done %0b busy %0b want 0 0", flush_done, flush_busy); end
    endtask
`else
    task automatic test_flush_disabled();
        mem_address = 32'h0000_0340; flush_req = 1; wb_ready = 1;
        tick();
        flush_req = 0;
        #1;
        tests++; if ({flush_busy, wb_valid, flush_done} !== 3'b000) begin fails++;
            $display("FAIL nf_outs got %b want 000", {flush_busy, wb_valid, flush_done}); end
        tests++; if (hit !== 1'b1 || hit_way !== 2'd2) begin fails++;
            $display("FAIL nf_hit got hit %0b way %0d want 1 2", hit, hit_way); end
        tick(); tick();
        tests++; if (hit !== 1'b1 || flush_done !== 1'b0) begin fails++;
            $display("FAIL nf_later got hit %0b done %0b want 1 0", hit, flush_done); end
        wb_ready = 0; rst = 1;
        tick();
        rst = 0;
        #1;
        tests++; if (hit !== 1'b0 || victim_valid !== 1'b0) begin fails++;
            $display("FAIL nf_reset got hit %0b vvalid %0b want 0 0", hit, victim_valid); end
    endtask
`endif

    initial begin
        line_x = {8{32'hCAFE_0ABC}};
        line_y = {8{32'h5A5A_0009}};
        test_reset();
        test_fill_plru();
        test_write_hit();
        test_dirty_victim();
`ifdef CACHE_FLUSH_EN
        test_flush();
        test_reset_mid_flush();
`else
        test_flush_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200us");
        $fatal(1, "watchdog expired");
    end

endmodule
